// File: rtl/iir_output_limiter.sv
// Output stage after the IIR filter: clamps the filter output to a window and
// slew-limits it on each update tick. It also flags a sustained rail condition.
module iir_output_limiter #(
  parameter int SIGNAL_SIZE = 16,
  parameter int RAIL_COUNT  = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          on_in,
  input  logic                          hold_in,
  input  logic signed [SIGNAL_SIZE-1:0] min_in,
  input  logic signed [SIGNAL_SIZE-1:0] max_in,
  input  logic        [SIGNAL_SIZE-1:0] step_in,
  input  logic        [15:0]            period_in,
  input  logic signed [SIGNAL_SIZE-1:0] signal_in,
  output logic signed [SIGNAL_SIZE-1:0] signal_out,
  output logic                          valid_out,
  output logic                          railed_out
);

  localparam int W = SIGNAL_SIZE;
  localparam logic [7:0] RAIL_MAX = 8'(RAIL_COUNT);

  typedef enum logic [1:0] {BYPASS, TRACK, HOLD} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [15:0]         r_tickCount;
  logic                w_tick;
  logic                w_bypass;
  logic                w_s1Load;
  logic                w_s2Update;

  logic                r_s1Valid;
  logic signed [W-1:0] r_target;
  logic                r_clamp;
  logic signed [W-1:0] w_target;
  logic                w_clamp;

  logic [W:0]          w_diff;
  logic [W:0]          w_absDiff;
  logic [W:0]          w_stepExt;
  logic                w_withinStep;
  logic [W-1:0]        w_stepped;
  logic signed [W-1:0] w_slewed;

  logic [7:0]          r_railCount;
  logic [7:0]          w_railNext;

  // The >= compare lets a shortened period fire on the very next cycle.
  assign w_tick = (r_tickCount >= period_in);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tickCount <= '0;
    end else if (w_tick) begin
      r_tickCount <= '0;
    end else begin
      r_tickCount <= r_tickCount + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= BYPASS;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BYPASS:  if (on_in) w_nextState = TRACK;
      TRACK: begin
        if (!on_in)       w_nextState = BYPASS;
        else if (hold_in) w_nextState = HOLD;
      end
      HOLD: begin
        if (!on_in)        w_nextState = BYPASS;
        else if (!hold_in) w_nextState = TRACK;
      end
      default: w_nextState = BYPASS;
    endcase
  end

  // Pipeline stages only advance in TRACK; HOLD and BYPASS drop in-flight work.
  always_comb begin
    w_bypass   = (r_state == BYPASS);
    w_s1Load   = (r_state == TRACK) && w_tick;
    w_s2Update = (r_state == TRACK) && r_s1Valid;
  end

  // An inverted window is treated as a misconfiguration and pinned at min_in.
  always_comb begin
    w_target = signal_in;
    w_clamp  = 1'b0;
    if (min_in > max_in) begin
      w_target = min_in;
      w_clamp  = 1'b1;
    end else if (signal_in < min_in) begin
      w_target = min_in;
      w_clamp  = 1'b1;
    end else if (signal_in > max_in) begin
      w_target = max_in;
      w_clamp  = 1'b1;
    end
  end

  // A partial step is only taken when |diff| > step, so W-bit arithmetic cannot wrap.
  always_comb begin
    w_diff       = {r_target[W-1], r_target} - {signal_out[W-1], signal_out};
    w_absDiff    = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
    w_stepExt    = {1'b0, step_in};
    w_withinStep = (step_in == '0) || (w_absDiff <= w_stepExt);
    w_stepped    = w_diff[W] ? (signal_out - step_in) : (signal_out + step_in);
    w_slewed     = w_withinStep ? r_target : $signed(w_stepped);
  end

  always_comb begin
    w_railNext = 8'd0;
    if (r_clamp) begin
      w_railNext = (r_railCount == RAIL_MAX) ? r_railCount : r_railCount + 8'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1Valid   <= 1'b0;
      r_target    <= '0;
      r_clamp     <= 1'b0;
      signal_out  <= '0;
      valid_out   <= 1'b0;
      railed_out  <= 1'b0;
      r_railCount <= '0;
    end else begin
      r_s1Valid <= w_s1Load;
      valid_out <= w_s2Update;
      if (w_s1Load) begin
        r_target <= w_target;
        r_clamp  <= w_clamp;
      end
      if (w_bypass) begin
        signal_out  <= signal_in;
        r_railCount <= '0;
        railed_out  <= 1'b0;
      end else if (w_s2Update) begin
        signal_out  <= w_slewed;
        r_railCount <= w_railNext;
        railed_out  <= (w_railNext == RAIL_MAX);
      end
    end
  end

endmodule

// File: tb/tb_iir_output_limiter.sv
// Directed bench for iir_output_limiter: bypass, clamp/rail, slew, hold,
// misconfigured window, period change and mid-run reset.
module tb_iir_output_limiter;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               on_in;
  logic               hold_in;
  logic signed [15:0] min_in;
  logic signed [15:0] max_in;
  logic        [15:0] step_in;
  logic        [15:0] period_in;
  logic signed [15:0] signal_in;
  logic signed [15:0] signal_out;
  logic               valid_out;
  logic               railed_out;

  int total = 0;
  int bad   = 0;

  iir_output_limiter #(.SIGNAL_SIZE(16), .RAIL_COUNT(8)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .on_in     (on_in),
    .hold_in   (hold_in),
    .min_in    (min_in),
    .max_in    (max_in),
    .step_in   (step_in),
    .period_in (period_in),
    .signal_in (signal_in),
    .signal_out(signal_out),
    .valid_out (valid_out),
    .railed_out(railed_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic stepCycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic on, input logic hold,
                               input logic signed [15:0] mn, input logic signed [15:0] mx,
                               input logic [15:0] st, input logic [15:0] per,
                               input logic signed [15:0] sig);
    on_in     = on;
    hold_in   = hold;
    min_in    = mn;
    max_in    = mx;
    step_in   = st;
    period_in = per;
    signal_in = sig;
  endtask

  task automatic checkOutput(input string tag, input logic signed [15:0] obs,
                             input logic signed [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic waitValid(input int budget, output int cycles);
    cycles = 0;
    do begin
      stepCycle();
      cycles++;
    end while (!valid_out && cycles < budget);
    checkBit("valid_timeout", valid_out, 1'b1);
  endtask

  initial begin
    int cyc;
    int e;

    // Reset held for three cycles with the servo requested on.
    rst_in = 1'b1;
    applyStimulus(1'b1, 1'b0, -16'sd1000, 16'sd1000, 16'd0, 16'd3, 16'sd5000);
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    on_in  = 1'b0;
    checkOutput("reset_out", signal_out, 16'sd0);
    checkBit("reset_valid", valid_out, 1'b0);
    checkBit("reset_railed", railed_out, 1'b0);

    // Bypass ramp: output follows input one cycle later.
    for (int i = 0; i <= 100; i++) begin
      signal_in = 16'(i);
      stepCycle();
      checkOutput("bypass_out", signal_out, 16'(i));
      checkBit("bypass_valid", valid_out, 1'b0);
    end

    // Clamp at max and rail after 8 clamped updates.
    applyStimulus(1'b0, 1'b0, -16'sd1000, 16'sd1000, 16'd0, 16'd3, 16'sd5000);
    stepCycle();
    on_in = 1'b1;
    for (int u = 1; u <= 8; u++) begin
      waitValid(12, cyc);
      if (u > 1) checkOutput("clamp_gap", 16'(cyc), 16'sd4);
      checkOutput("clamp_out", signal_out, 16'sd1000);
      checkBit("clamp_railed", railed_out, (u == 8));
    end
    signal_in = 16'sd0;
    waitValid(12, cyc);
    checkOutput("unclamp_out", signal_out, 16'sd0);
    checkBit("unclamp_railed", railed_out, 1'b0);

    // Slew up toward 350 in steps of 100.
    applyStimulus(1'b1, 1'b0, 16'sh8000, 16'sh7FFF, 16'd100, 16'd3, 16'sd350);
    waitValid(12, cyc);
    checkOutput("slew_up1", signal_out, 16'sd100);
    waitValid(12, cyc);
    checkOutput("slew_up2", signal_out, 16'sd200);
    waitValid(12, cyc);
    checkOutput("slew_up3", signal_out, 16'sd300);
    waitValid(12, cyc);
    checkOutput("slew_up4", signal_out, 16'sd350);
    waitValid(12, cyc);
    checkOutput("slew_steady", signal_out, 16'sd350);

    // Slew down to the most negative code without wrapping.
    signal_in = 16'sh8000;
    e = 350;
    while (e != -32768) begin
      e = e - 100;
      if (e < -32768) e = -32768;
      waitValid(12, cyc);
      checkOutput("slew_down", signal_out, 16'(e));
    end
    waitValid(12, cyc);
    checkOutput("slew_floor", signal_out, 16'sh8000);

    // Full-scale step must be treated as unsigned.
    step_in   = 16'hFFFF;
    signal_in = 16'sh7FFF;
    waitValid(12, cyc);
    checkOutput("slew_fullstep", signal_out, 16'sh7FFF);

    // Hold entered straight from bypass keeps the bypassed value.
    on_in     = 1'b0;
    signal_in = 16'sd500;
    stepCycle();
    stepCycle();
    checkOutput("hold_bypass_out", signal_out, 16'sd500);
    checkBit("hold_bypass_railed", railed_out, 1'b0);
    on_in   = 1'b1;
    hold_in = 1'b1;
    step_in = 16'd200;
    stepCycle();
    checkOutput("hold_enter_out", signal_out, 16'sd500);
    signal_in = 16'sd800;
    for (int i = 0; i < 11; i++) begin
      stepCycle();
      checkOutput("hold_out", signal_out, 16'sd500);
      checkBit("hold_valid", valid_out, 1'b0);
    end
    hold_in = 1'b0;
    waitValid(12, cyc);
    checkOutput("release_1", signal_out, 16'sd700);
    waitValid(12, cyc);
    checkOutput("release_gap", 16'(cyc), 16'sd4);
    checkOutput("release_2", signal_out, 16'sd800);

    // Inverted window pins at min and counts as clamped.
    min_in    = 16'sd10;
    max_in    = -16'sd10;
    step_in   = 16'd0;
    signal_in = 16'sd0;
    for (int u = 1; u <= 8; u++) begin
      waitValid(12, cyc);
      checkOutput("misconfig_out", signal_out, 16'sd10);
      checkBit("misconfig_railed", railed_out, (u == 8));
    end

    // Shortening the period below the running count ticks on the next cycle.
    applyStimulus(1'b1, 1'b0, 16'sh8000, 16'sh7FFF, 16'd0, 16'd1000, 16'sd1234);
    waitValid(1100, cyc);
    checkOutput("longperiod_out", signal_out, 16'sd1234);
    repeat (199) stepCycle();
    checkBit("longperiod_quiet", valid_out, 1'b0);
    period_in = 16'd5;
    signal_in = -16'sd77;
    stepCycle();
    checkBit("shortperiod_stage1", valid_out, 1'b0);
    stepCycle();
    checkBit("shortperiod_valid", valid_out, 1'b1);
    checkOutput("shortperiod_out", signal_out, -16'sd77);

    // Reset mid-run discards the in-flight update.
    period_in = 16'd0;
    signal_in = 16'sd3000;
    stepCycle();
    rst_in = 1'b1;
    stepCycle();
    rst_in = 1'b0;
    checkOutput("midreset_out", signal_out, 16'sd0);
    checkBit("midreset_valid", valid_out, 1'b0);
    checkBit("midreset_railed", railed_out, 1'b0);
    stepCycle();
    checkBit("midreset_after_valid", valid_out, 1'b0);
    checkOutput("midreset_after_out", signal_out, 16'sd3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
